// File: rtl/axin_pkt_buffer.sv
// Store-and-forward packet FIFO: only whole, clean packets reach the egress port; LAST accepted at
// edge N gives M_VALID at edge N+2. Ingress never backpressures; aborted or overflowing packets are dropped.
module axin_pkt_buffer #(
   parameter int DW     = 64,
   parameter int WBITS  = $clog2(DW/8),
   parameter int LGFLEN = 9,
   parameter int DROPW  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              S_VALID,
   output logic              S_READY,
   input  logic [DW-1:0]     S_DATA,
   input  logic [WBITS-1:0]  S_BYTES,
   input  logic              S_LAST,
   input  logic              S_ABORT,
   output logic              M_VALID,
   input  logic              M_READY,
   output logic [DW-1:0]     M_DATA,
   output logic [WBITS-1:0]  M_BYTES,
   output logic              M_LAST,
   output logic [DROPW-1:0]  o_drops,
   output logic [LGFLEN:0]   o_fill
);
   localparam int MW = 1 + WBITS + DW;
   localparam logic [LGFLEN:0] DEPTH   = {1'b1, {LGFLEN{1'b0}}};
   localparam logic [LGFLEN:0] PTR_ONE = {{LGFLEN{1'b0}}, 1'b1};
   localparam logic [DROPW-1:0] DROP_ONE = {{(DROPW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MIDPKT = 2'd1,
      ST_DROP   = 2'd2
   } wr_state_t;

   wr_state_t        state;
   wr_state_t        state_nxt;
   logic [LGFLEN:0]  wr_ptr;
   logic [LGFLEN:0]  wr_commit;
   logic [LGFLEN:0]  rd_ptr;
   logic [DROPW-1:0] drops;
   logic             s_ready_q;
   logic             accept;
   logic             full;
   logic             store_beat;
   logic             commit;
   logic             rewind;
   logic             drop_inc;

   logic [MW-1:0]    mem [0:(1<<LGFLEN)-1];
   logic             rd_avail;
   logic             rd_load;
   logic             out_ready;
   logic             rd_vld;
   logic [MW-1:0]    rd_word;
   logic             m_vld;
   logic [MW-1:0]    m_word;

   assign S_READY = s_ready_q;
   assign accept  = S_VALID && s_ready_q;
   assign o_fill  = wr_ptr - rd_ptr;
   assign full    = (o_fill == DEPTH);
   assign o_drops = drops;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_IDLE;
         s_ready_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         s_ready_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_MIDPKT: begin
            if (state == ST_MIDPKT && S_ABORT) begin
               state_nxt = ST_IDLE;
            end else if (accept && !S_ABORT) begin
               if (S_LAST)
                  state_nxt = ST_IDLE;
               else if (full)
                  state_nxt = ST_DROP;
               else
                  state_nxt = ST_MIDPKT;
            end
         end
         ST_DROP: begin
            if (S_ABORT || (accept && S_LAST))
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Full is judged on the registered pointers, so a same-cycle read never rescues a beat.
   always_comb begin
      store_beat = 1'b0;
      commit     = 1'b0;
      rewind     = 1'b0;
      drop_inc   = 1'b0;
      case (state)
         ST_IDLE, ST_MIDPKT: begin
            if (state == ST_MIDPKT && S_ABORT) begin
               rewind   = 1'b1;
               drop_inc = 1'b1;
            end else if (accept && !S_ABORT) begin
               if (full) begin
                  rewind   = 1'b1;
                  drop_inc = 1'b1;
               end else begin
                  store_beat = 1'b1;
                  commit     = S_LAST;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr    <= '0;
         wr_commit <= '0;
         drops     <= '0;
      end else begin
         if (rewind)
            wr_ptr <= wr_commit;
         else if (store_beat)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (commit)
            wr_commit <= wr_ptr + PTR_ONE;
         if (drop_inc)
            drops <= drops + DROP_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (store_beat)
         mem[wr_ptr[LGFLEN-1:0]] <= {S_LAST, S_BYTES, S_DATA};
   end

   // Two-stage read: registered RAM output feeding the egress register, so beats stream one per clock.
   assign rd_avail  = (rd_ptr != wr_commit);
   assign out_ready = !m_vld || M_READY;
   assign rd_load   = rd_avail && (!rd_vld || out_ready);

   always_ff @(posedge i_clk) begin
      if (rd_load)
         rd_word <= mem[rd_ptr[LGFLEN-1:0]];
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_ptr <= '0;
         rd_vld <= 1'b0;
      end else if (rd_load) begin
         rd_ptr <= rd_ptr + PTR_ONE;
         rd_vld <= 1'b1;
      end else if (out_ready) begin
         rd_vld <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         m_vld  <= 1'b0;
         m_word <= '0;
      end else if (out_ready) begin
         m_vld  <= rd_vld;
         m_word <= rd_vld ? rd_word : '0;
      end
   end

   assign M_VALID = m_vld;
   assign M_LAST  = m_word[MW-1];
   assign M_BYTES = m_word[DW +: WBITS];
   assign M_DATA  = m_word[DW-1:0];

endmodule

// File: tb/tb_axin_pkt_buffer.sv
// Scoreboard bench for axin_pkt_buffer; a 16-beat instance covers the overflow cases.
module tb_axin_pkt_buffer;
   localparam int DW    = 64;
   localparam int WBITS = 3;
   localparam int MW    = 1 + WBITS + DW;

   logic             i_clk = 1'b0;
   logic             i_reset_n = 1'b0;
   logic             S_VALID = 1'b0;
   logic             S_LAST = 1'b0;
   logic             S_ABORT = 1'b0;
   logic             M_READY = 1'b0;
   logic [DW-1:0]    S_DATA = '0;
   logic [WBITS-1:0] S_BYTES = '0;

   logic             S_READY, M_VALID, M_LAST;
   logic [DW-1:0]    M_DATA;
   logic [WBITS-1:0] M_BYTES;
   logic [15:0]      o_drops;
   logic [9:0]       o_fill;

   logic             s_ready4, m_valid4, m_last4;
   logic [DW-1:0]    m_data4;
   logic [WBITS-1:0] m_bytes4;
   logic [15:0]      drops4;
   logic [4:0]       fill4;

   int               tests = 0;
   int               fails = 0;
   int               exp_drops = 0;
   bit               mon_en = 1'b0;
   bit               rand_rdy = 1'b0;
   logic [MW-1:0]    exp_q[$];
   logic [MW-1:0]    exp4_q[$];
   bit               stall_prev = 1'b0;
   logic [MW:0]      prev_word = '0;

   axin_pkt_buffer #(.DW(DW), .LGFLEN(9), .DROPW(16)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_BYTES(S_BYTES),
      .S_LAST(S_LAST), .S_ABORT(S_ABORT),
      .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_BYTES(M_BYTES),
      .M_LAST(M_LAST), .o_drops(o_drops), .o_fill(o_fill)
   );

   axin_pkt_buffer #(.DW(DW), .LGFLEN(4), .DROPW(16)) dut4 (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .S_VALID(S_VALID), .S_READY(s_ready4), .S_DATA(S_DATA), .S_BYTES(S_BYTES),
      .S_LAST(S_LAST), .S_ABORT(S_ABORT),
      .M_VALID(m_valid4), .M_READY(M_READY), .M_DATA(m_data4), .M_BYTES(m_bytes4),
      .M_LAST(m_last4), .o_drops(drops4), .o_fill(fill4)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (rand_rdy) M_READY = ($urandom_range(0, 9) >= 3);
      end
   end

   // Egress monitor: pops the scoreboard on every handshake and checks hold-under-stall.
   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         stall_prev = 1'b0;
      end else begin
         if (mon_en && stall_prev) begin
            tests++;
            if ({M_VALID, M_LAST, M_BYTES, M_DATA} !== prev_word) begin
               fails++;
               $display("FAIL stall_stable: got %h want %h", {M_VALID, M_LAST, M_BYTES, M_DATA}, prev_word);
            end
         end
         if (mon_en && M_VALID && M_READY) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_beat: got %h want nothing", {M_LAST, M_BYTES, M_DATA});
            end else begin
               logic [MW-1:0] e;
               e = exp_q.pop_front();
               if ({M_LAST, M_BYTES, M_DATA} !== e) begin
                  fails++;
                  $display("FAIL beat_data: got %h want %h", {M_LAST, M_BYTES, M_DATA}, e);
               end
            end
         end
         stall_prev = M_VALID && !M_READY;
         prev_word  = {M_VALID, M_LAST, M_BYTES, M_DATA};
      end
   end

   task automatic do_reset();
      i_reset_n = 1'b0;
      S_VALID = 1'b0; S_LAST = 1'b0; S_ABORT = 1'b0; S_DATA = '0; S_BYTES = '0;
      exp_q.delete();
      exp4_q.delete();
      exp_drops = 0;
      repeat (2) @(posedge i_clk);
      #1 i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   // dest: 0 = expect nothing, 1 = main scoreboard, 2 = 16-deep instance scoreboard
   task automatic send_pkt(input int len, input logic [WBITS-1:0] nbytes, input int abort_at,
                           input bit abort_vld, input int dest);
      for (int i = 0; i < len; i++) begin
         if (i == abort_at) begin
            S_VALID = abort_vld; S_DATA = {$urandom, $urandom}; S_LAST = 1'b0;
            S_BYTES = '0; S_ABORT = 1'b1;
            @(posedge i_clk);
            #1;
            S_ABORT = 1'b0; S_VALID = 1'b0;
            return;
         end
         S_VALID = 1'b1;
         S_DATA  = {$urandom, $urandom};
         S_LAST  = (i == len - 1);
         S_BYTES = S_LAST ? nbytes : '0;
         if (dest == 1) exp_q.push_back({S_LAST, S_BYTES, S_DATA});
         if (dest == 2) exp4_q.push_back({S_LAST, S_BYTES, S_DATA});
         @(posedge i_clk);
         #1;
      end
      S_VALID = 1'b0; S_LAST = 1'b0; S_BYTES = '0;
   endtask

   task automatic wait_empty(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge i_clk);
         #1;
      end
      repeat (4) @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge i_clk);
      #1;
      tests++; if (S_READY !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %0b want 0", S_READY); end
      tests++; if (M_VALID !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %0b want 0", M_VALID); end
      tests++; if ({M_LAST, M_BYTES, M_DATA} !== '0) begin fails++; $display("FAIL reset_m_word: got %h want 0", {M_LAST, M_BYTES, M_DATA}); end
      tests++; if (o_drops !== 16'd0) begin fails++; $display("FAIL reset_drops: got %0d want 0", o_drops); end
      tests++; if (o_fill !== 10'd0 || fill4 !== 5'd0) begin fails++; $display("FAIL reset_fill: got %0d/%0d want 0/0", o_fill, fill4); end
      #1 i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
      tests++; if (S_READY !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %0b want 1", S_READY); end
   endtask

   task automatic test_basic();
      bit ok;
      M_READY = 1'b1;
      mon_en  = 1'b1;
      send_pkt(3, 3'd5, -1, 1'b0, 1);
      tests++; if (M_VALID !== 1'b0) begin fails++; $display("FAIL latency_n0: got %0b want 0", M_VALID); end
      tests++; if (o_fill !== 10'd3) begin fails++; $display("FAIL fill_at_commit: got %0d want 3", o_fill); end
      @(posedge i_clk);
      #1;
      tests++; if (M_VALID !== 1'b0) begin fails++; $display("FAIL latency_n1: got %0b want 0", M_VALID); end
      @(posedge i_clk);
      #1;
      tests++; if (M_VALID !== 1'b1) begin fails++; $display("FAIL latency_n2: got %0b want 1", M_VALID); end
      wait_empty(20, ok);
      tests++; if (!ok) begin fails++; $display("FAIL basic_drain: got %0d left want 0", exp_q.size()); end
      tests++; if (o_drops !== 16'(exp_drops) || o_fill !== 10'd0) begin
         fails++; $display("FAIL basic_counts: got drops=%0d fill=%0d want %0d/0", o_drops, o_fill, exp_drops); end
      tests++; if (M_VALID !== 1'b0 || M_DATA !== '0) begin
         fails++; $display("FAIL idle_zero: got vld=%0b data=%h want 0/0", M_VALID, M_DATA); end
   endtask

   task automatic test_abort();
      bit ok;
      send_pkt(6, 3'd0, 4, 1'b0, 0);
      exp_drops++;
      tests++; if (o_drops !== 16'(exp_drops)) begin fails++; $display("FAIL abort_drops: got %0d want %0d", o_drops, exp_drops); end
      tests++; if (o_fill !== 10'd0) begin fails++; $display("FAIL abort_fill: got %0d want 0", o_fill); end
      repeat (6) @(posedge i_clk);
      #1;
      send_pkt(2, 3'd3, -1, 1'b0, 1);
      wait_empty(20, ok);
      tests++; if (!ok) begin fails++; $display("FAIL abort_next_drain: got %0d left want 0", exp_q.size()); end
      tests++; if (o_drops !== 16'(exp_drops)) begin fails++; $display("FAIL abort_next_drops: got %0d want %0d", o_drops, exp_drops); end
   endtask

   task automatic test_oversize();
      int got;
      do_reset();
      mon_en  = 1'b0;
      M_READY = 1'b0;
      send_pkt(20, 3'd0, -1, 1'b0, 0);
      tests++; if (drops4 !== 16'd1) begin fails++; $display("FAIL oversize_drops: got %0d want 1", drops4); end
      tests++; if (fill4 !== 5'd0) begin fails++; $display("FAIL oversize_fill: got %0d want 0", fill4); end
      send_pkt(16, 3'd7, -1, 1'b0, 2);
      tests++; if (fill4 !== 5'd16) begin fails++; $display("FAIL exact_full_fill: got %0d want 16", fill4); end
      tests++; if (drops4 !== 16'd1) begin fails++; $display("FAIL exact_full_drops: got %0d want 1", drops4); end
      M_READY = 1'b1;
      got = 0;
      for (int c = 0; c < 60 && exp4_q.size() > 0; c++) begin
         @(negedge i_clk);
         if (m_valid4) begin
            logic [MW-1:0] e;
            e = exp4_q.pop_front();
            got++;
            tests++;
            if ({m_last4, m_bytes4, m_data4} !== e) begin
               fails++; $display("FAIL full_pkt_beat: got %h want %h", {m_last4, m_bytes4, m_data4}, e); end
         end
      end
      @(posedge i_clk);
      #1;
      tests++; if (got !== 16) begin fails++; $display("FAIL full_pkt_count: got %0d want 16", got); end
      do_reset();
   endtask

   task automatic test_abort_mid();
      bit ok;
      M_READY = 1'b1;
      mon_en  = 1'b1;
      send_pkt(3, 3'd2, -1, 1'b0, 1);
      send_pkt(5, 3'd0, 2, 1'b1, 0);
      exp_drops++;
      wait_empty(30, ok);
      tests++; if (!ok) begin fails++; $display("FAIL mid_abort_drain: got %0d left want 0", exp_q.size()); end
      tests++; if (o_drops !== 16'(exp_drops) || o_fill !== 10'd0) begin
         fails++; $display("FAIL mid_abort_counts: got drops=%0d fill=%0d want %0d/0", o_drops, o_fill, exp_drops); end
   endtask

   task automatic test_random();
      bit ok;
      int len, ab;
      rand_rdy = 1'b1;
      for (int p = 0; p < 100; p++) begin
         len = $urandom_range(1, 8);
         ab  = -1;
         if (len > 1 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, len - 1);
         if (ab >= 0) exp_drops++;
         send_pkt(len, 3'($urandom_range(0, 7)), ab, 1'($urandom_range(0, 1)), (ab < 0) ? 1 : 0);
         repeat ($urandom_range(0, 2)) @(posedge i_clk);
         #1;
      end
      wait_empty(3000, ok);
      rand_rdy = 1'b0;
      @(posedge i_clk);
      #2 M_READY = 1'b1;
      tests++; if (!ok) begin fails++; $display("FAIL random_drain: got %0d left want 0", exp_q.size()); end
      tests++; if (o_drops !== 16'(exp_drops)) begin fails++; $display("FAIL random_drops: got %0d want %0d", o_drops, exp_drops); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      M_READY = 1'b0;
      mon_en  = 1'b1;
      send_pkt(6, 3'd4, -1, 1'b0, 1);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (M_VALID) seen = 1'b1;
         else begin @(posedge i_clk); #1; end
      end
      tests++; if (!seen) begin fails++; $display("FAIL pre_reset_valid: got 0 want 1"); end
      #2 i_reset_n = 1'b0;
      #1;
      tests++; if (M_VALID !== 1'b0 || M_DATA !== '0) begin
         fails++; $display("FAIL async_reset_out: got vld=%0b data=%h want 0/0", M_VALID, M_DATA); end
      tests++; if (o_fill !== 10'd0) begin fails++; $display("FAIL async_reset_fill: got %0d want 0", o_fill); end
      exp_q.delete();
      exp_drops = 0;
      repeat (2) @(posedge i_clk);
      #1 i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
      M_READY = 1'b1;
      send_pkt(2, 3'd6, -1, 1'b0, 1);
      wait_empty(20, ok);
      tests++; if (!ok) begin fails++; $display("FAIL post_reset_drain: got %0d left want 0", exp_q.size()); end
      tests++; if (o_drops !== 16'd0) begin fails++; $display("FAIL post_reset_drops: got %0d want 0", o_drops); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_abort();
      test_oversize();
      test_abort_mid();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
